// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Board-pin front end for push-buttons and toggle switches.
//               Each raw pin is (optionally inverted,) synchronised into
//               clkIn, debounced by a per-channel stable-count filter, and
//               presented as a clean level plus registered one-cycle strobes:
//               button press / release per channel, and a single "any switch
//               changed" strobe.
//
// Ports       : clkIn            - system clock, all state on rising edge
//               resetIn          - synchronous active-high reset
//               buttonsIn        - raw asynchronous button pins
//               switchesIn       - raw asynchronous switch pins
//               buttonLevelOut   - debounced button level, 1 = pressed
//               buttonPressOut   - one-cycle strobe on debounced 0->1
//               buttonReleaseOut - one-cycle strobe on debounced 1->0
//               switchesOut      - debounced switch levels
//               switchChangeOut  - one-cycle strobe when any switch changes
//
// Options     : `define BUTTON_REPEAT_EN to build the per-button auto-repeat
//               (extra press strobes while a button is held, first after
//               REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
//
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module input_conditioner #(
    parameter int NUM_BUTTONS       = 4,
    parameter int SWITCH_WIDTH      = 12,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int BUTTON_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY      = 25000000,
    parameter int REPEAT_PERIOD     = 5000000
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic [NUM_BUTTONS-1:0]  buttonsIn,
    input  logic [SWITCH_WIDTH-1:0] switchesIn,
    output logic [NUM_BUTTONS-1:0]  buttonLevelOut,
    output logic [NUM_BUTTONS-1:0]  buttonPressOut,
    output logic [NUM_BUTTONS-1:0]  buttonReleaseOut,
    output logic [SWITCH_WIDTH-1:0] switchesOut,
    output logic                    switchChangeOut
);

    // Buttons and switches share one channel vector: buttons occupy the low
    // bits, switches the high bits. Every channel gets identical logic.
    localparam int NB = NUM_BUTTONS;
    localparam int NCH = NUM_BUTTONS + SWITCH_WIDTH;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB-1:0] c_BTN_INV = {NB{BUTTON_ACTIVE_LOW != 0}};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_chk_repeat
        $error("input_conditioner: need REPEAT_DELAY >= 2 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    // ------------------------------------------------------------------------
    // Inversion ahead of the synchroniser, so that the all-zero reset state of
    // the chain already means "released" for active-low buttons.
    // ------------------------------------------------------------------------
    logic [NCH-1:0] w_raw;
    assign w_raw = {switchesIn, buttonsIn ^ c_BTN_INV};

    logic [NCH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    logic [NCH-1:0] w_sync;
    logic [NCH-1:0] w_stable;
    logic [NCH-1:0] w_accept;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Per-channel debounce: the counter only runs while the synchronised
    // value disagrees with the stable value, and any agreement clears it, so
    // short glitches never build up a partial count.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic [CW-1:0] r_cnt;
        logic          r_stable;
        logic          w_diff;

        assign w_diff      = w_sync[c] ^ r_stable;
        assign w_accept[c] = w_diff && (r_cnt == c_CNT_MAX);
        assign w_stable[c] = r_stable;

        always_ff @(posedge clkIn) begin
            if (resetIn) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept[c]) begin
                r_stable <= w_sync[c];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Auto-repeat of button press strobes
    // ------------------------------------------------------------------------
    logic [NB-1:0] w_rep_fire;

`ifdef BUTTON_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] c_REP_MAX = RW'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next wrap PERIOD cycles away.
    localparam logic [RW-1:0] c_REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    for (genvar b = 0; b < NB; b++) begin : g_repeat
        logic [RW-1:0] r_rep;

        // Suppressed on the accept cycle of a release, which is the only
        // accept possible while the stable level is 1.
        assign w_rep_fire[b] = w_stable[b] && !w_accept[b] && (r_rep == c_REP_MAX);

        always_ff @(posedge clkIn) begin
            if (resetIn) begin
                r_rep <= '0;
            end else if (!w_stable[b] || w_accept[b]) begin
                r_rep <= '0;
            end else if (r_rep == c_REP_MAX) begin
                r_rep <= c_REP_RELOAD;
            end else begin
                r_rep <= r_rep + 1'b1;
            end
        end
    end
`else
    assign w_rep_fire = '0;
`endif

    // ------------------------------------------------------------------------
    // Registered strobes: they are loaded on the same edge as the stable
    // value, so each strobe lines up with the first cycle of the new level.
    // ------------------------------------------------------------------------
    logic [NB-1:0] r_press;
    logic [NB-1:0] r_release;
    logic          r_change;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            r_press   <= '0;
            r_release <= '0;
            r_change  <= 1'b0;
        end else begin
            r_press   <= (w_accept[NB-1:0] & w_sync[NB-1:0]) | w_rep_fire;
            r_release <= w_accept[NB-1:0] & ~w_sync[NB-1:0];
            r_change  <= |w_accept[NCH-1:NB];
        end
    end

    assign buttonLevelOut   = w_stable[NB-1:0];
    assign switchesOut      = w_stable[NCH-1:NB];
    assign buttonPressOut   = r_press;
    assign buttonReleaseOut = r_release;
    assign switchChangeOut  = r_change;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Directed self-checking bench for input_conditioner with
//               SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (input-to-output latency of
//               6 edges), REPEAT_DELAY=10, REPEAT_PERIOD=5. All outputs are
//               packed into one vector and compared against hand-computed
//               expectations one cycle at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int NB = 4;
    localparam int SW = 12;

`ifdef BUTTON_REPEAT_EN
    localparam bit c_REP = 1'b1;
`else
    localparam bit c_REP = 1'b0;
`endif

    logic          clkIn = 1'b0;
    logic          resetIn;
    logic [NB-1:0] buttonsIn;
    logic [SW-1:0] switchesIn;
    logic [NB-1:0] buttonLevelOut;
    logic [NB-1:0] buttonPressOut;
    logic [NB-1:0] buttonReleaseOut;
    logic [SW-1:0] switchesOut;
    logic          switchChangeOut;

    input_conditioner #(
        .NUM_BUTTONS      (NB),
        .SWITCH_WIDTH     (SW),
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .BUTTON_ACTIVE_LOW(1),
        .REPEAT_DELAY     (10),
        .REPEAT_PERIOD    (5)
    ) dut (
        .clkIn           (clkIn),
        .resetIn         (resetIn),
        .buttonsIn       (buttonsIn),
        .switchesIn      (switchesIn),
        .buttonLevelOut  (buttonLevelOut),
        .buttonPressOut  (buttonPressOut),
        .buttonReleaseOut(buttonReleaseOut),
        .switchesOut     (switchesOut),
        .switchChangeOut (switchChangeOut)
    );

    always #5 clkIn = ~clkIn;

    // {level[3:0], press[3:0], release[3:0], switches[11:0], change}
    logic [24:0] obs;
    logic [24:0] exp_v;
    assign obs = {buttonLevelOut, buttonPressOut, buttonReleaseOut, switchesOut, switchChangeOut};

    int n_cmp = 0;
    int n_err = 0;

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic test_reset();
        resetIn    = 1'b1;
        buttonsIn  = 4'hF;
        switchesIn = 12'h000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_v = '0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        resetIn = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = '0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_after[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_press_release();
        buttonsIn = 4'hB;               // button 2 pressed (active low)
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = '0;
            else if (k == 6) exp_v = {4'b0100, 4'b0100, 4'b0000, 12'h000, 1'b0};
            else             exp_v = {4'b0100, 4'b0000, 4'b0000, 12'h000, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL press_b2[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        buttonsIn = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = {4'b0100, 4'b0000, 4'b0000, 12'h000, 1'b0};
            else if (k == 6) exp_v = {4'b0000, 4'b0000, 4'b0100, 12'h000, 1'b0};
            else             exp_v = '0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL release_b2[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8];
        seq = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF};
        for (int k = 0; k < 8; k++) begin
            buttonsIn = seq[k];
            tick();
            exp_v = '0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL bounce[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        buttonsIn = 4'hE;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = '0;
            else if (k == 6) exp_v = {4'b0001, 4'b0001, 4'b0000, 12'h000, 1'b0};
            else             exp_v = {4'b0001, 4'b0000, 4'b0000, 12'h000, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL bounce_settle[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        buttonsIn = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = {4'b0001, 4'b0000, 4'b0000, 12'h000, 1'b0};
            else if (k == 6) exp_v = {4'b0000, 4'b0000, 4'b0001, 12'h000, 1'b0};
            else             exp_v = '0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL bounce_release[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_switches();
        switchesIn = 12'hA5C;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = '0;
            else if (k == 6) exp_v = {12'h000, 12'hA5C, 1'b1};
            else             exp_v = {12'h000, 12'hA5C, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL switch_step[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        // Two-cycle glitch on bit 11 must be filtered out.
        for (int k = 1; k <= 10; k++) begin
            switchesIn = (k <= 2) ? 12'h25C : 12'hA5C;
            tick();
            exp_v = {12'h000, 12'hA5C, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL switch_glitch[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Buttons 0 and 3 plus a switch bit change on the same cycle.
        buttonsIn  = 4'h6;
        switchesIn = 12'hA5D;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = {12'h000, 12'hA5C, 1'b0};
            else if (k == 6) exp_v = {4'b1001, 4'b1001, 4'b0000, 12'hA5D, 1'b1};
            else             exp_v = {4'b1001, 4'b0000, 4'b0000, 12'hA5D, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL multi_press[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        buttonsIn = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = {4'b1001, 4'b0000, 4'b0000, 12'hA5D, 1'b0};
            else if (k == 6) exp_v = {4'b0000, 4'b0000, 4'b1001, 12'hA5D, 1'b0};
            else             exp_v = {12'h000, 12'hA5D, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL multi_release[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        buttonsIn = 4'hD;               // button 1 pressed
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = {12'h000, 12'hA5D, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL mid_debounce[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        resetIn = 1'b1;
        tick();
        exp_v = '0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mid_reset: got %h want %h", obs, exp_v);
        end
        resetIn = 1'b0;
        // Button still held and switches still set: both re-debounce.
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       exp_v = '0;
            else if (k == 6) exp_v = {4'b0010, 4'b0010, 4'b0000, 12'hA5D, 1'b1};
            else             exp_v = {4'b0010, 4'b0000, 4'b0000, 12'hA5D, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL post_reset[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    // Continues from press cycle P of button 1 (bench is now at P+1). The
    // pin is released after P+24 so the level drops at P+30, the cycle a
    // repeat would otherwise have fired.
    task automatic test_hold_repeat();
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        for (int k = 2; k <= 40; k++) begin
            tick();
            lvl = (k < 30) ? 4'b0010 : 4'b0000;
            rel = (k == 30) ? 4'b0010 : 4'b0000;
            prs = (c_REP && (k == 10 || k == 15 || k == 20 || k == 25)) ? 4'b0010 : 4'b0000;
            exp_v = {lvl, prs, rel, 12'hA5D, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL hold_p+%0d: got %h want %h", k, obs, exp_v);
            end
            if (k == 24) buttonsIn = 4'hF;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetIn    = 1'b1;
        buttonsIn  = 4'hF;
        switchesIn = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_switches();
        test_back_to_back();
        test_reset_mid_debounce();
        test_hold_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised successor to the board input wrapper.
- Takes raw push-buttons and toggle switches from board pins. Synchronises them to clkIn, debounces them, and produces clean levels plus one-cycle press/release/change strobes for the control FSMs.
- Sits directly behind the pins, ahead of all control logic.

Parameters:
NUM_BUTTONS, 4, number of push-button channels (reset/set/load/start on the current board)
SWITCH_WIDTH, 12, number of toggle-switch bits (SW17..SW6 on the current board)
SYNC_STAGES, 2, synchroniser flops per input bit; must be >= 2
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new value; must be >= 2
BUTTON_ACTIVE_LOW, 1, 1 = raw button pin reads 0 when pressed (inverted before synchronising)
REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (BUTTON_REPEAT_EN only)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (BUTTON_REPEAT_EN only)

Ports:
clkIn  input  1  system clock; all state on rising edge
resetIn  input  1  synchronous, active-high reset
buttonsIn  input  NUM_BUTTONS  raw asynchronous button pins
switchesIn  input  SWITCH_WIDTH  raw asynchronous switch pins
buttonLevelOut  output  NUM_BUTTONS  debounced level, 1 = pressed
buttonPressOut  output  NUM_BUTTONS  one-cycle strobe on a debounced 0->1 transition
buttonReleaseOut  output  NUM_BUTTONS  one-cycle strobe on a debounced 1->0 transition
switchesOut  output  SWITCH_WIDTH  debounced switch levels
switchChangeOut  output  1  one-cycle strobe when any debounced switch bit changes

Behaviour:
- One clock (clkIn). Reset is synchronous and active-high (resetIn), sampled on the clkIn rising edge.
- Reset: all synchroniser flops, debounce counters, stable registers and outputs go to 0, i.e. logical released / off.
  - With BUTTON_ACTIVE_LOW=1, the inversion happens before the synchroniser, so reset state means released.
- Channel structure: identical logic for every button bit and every switch bit.
  - Raw input, XOR-ed with BUTTON_ACTIVE_LOW for buttons only, feeds the SYNC_STAGES-flop chain; its output is "sync".
  - Per channel: a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
- Debounce rule, evaluated every cycle:
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES clears the counter; partial counts never accumulate.
- Latency: a clean input step reaches buttonLevelOut/switchesOut exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after it is first sampled.
- Strobes are registered and asserted for exactly one cycle, in the same cycle the new stable value first appears on the level output.
  - buttonPressOut[i]: stable 0->1.
  - buttonReleaseOut[i]: stable 1->0.
  - switchChangeOut: OR over all switch bits of a stable change. Simultaneous changes on several bits give one pulse.
- Press and release of the same channel can never assert together. Different channels are fully independent; simultaneous strobes are allowed.
- Reset mid-debounce: counters and stables clear immediately and all strobes deassert in the next cycle.
  - A button still held after reset is released is re-debounced from scratch. It yields exactly one press strobe SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
- Switches held at 1 through reset likewise produce one switchChangeOut after that same latency.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BUTTON_REPEAT_EN.
- Defined: each button gets a repeat counter.
  - Cleared while stable == 0 and on buttonPressOut.
  - Counts while stable == 1.
  - When the count reaches REPEAT_DELAY-1, buttonPressOut pulses again and the counter reloads so that later pulses occur every REPEAT_PERIOD cycles while held.
  - Release clears the counter; no repeat pulse is issued in the release cycle.
- Undefined: no repeat logic is built. REPEAT_DELAY and REPEAT_PERIOD are unused, and exactly one press strobe is issued per debounced press.

Test Plan:
1. Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, NUM_BUTTONS=4, SWITCH_WIDTH=12, BUTTON_ACTIVE_LOW=1. Hold resetIn=1 for 3 cycles with buttonsIn=4'hF -> all outputs 0 during reset and for 6 cycles after.
2. Drive buttonsIn[2] 1->0 cleanly -> buttonLevelOut[2]=1 and a single-cycle buttonPressOut=4'b0100 on the 6th edge. Drive it back to 1 -> buttonReleaseOut=4'b0100 for one cycle 6 edges later.
3. Bounce buttonsIn[0]: low 3 cycles, high 1, low 3, high 1, then low steady -> no strobe during bouncing. Exactly one press strobe 6 edges after the final steady low.
4. Change switchesIn from 12'h000 to 12'hA5C in one cycle -> switchesOut=12'hA5C and one switchChangeOut pulse after 6 edges. A 2-cycle glitch on bit 11 afterwards -> no change.
5. Assert resetIn for 1 cycle mid-debounce (counter=2) with button still pressed -> outputs 0, counter 0. One press strobe 6 edges after reset deasserts.
6. With BUTTON_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold button 1 for 30 cycles past its press -> press strobes at +0, +10, +15, +20, +25. Release -> release strobe, no further presses.
